// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester-side byte streams, the UART tx core handshake and
//   the arbiter status outputs into one interface.
//   Ports (signals):
//     req_valid/req_data/req_last  requester byte streams (N_REQ lanes, 8 bits each)
//     req_ready                    per-requester accept strobe
//     tx_valid/tx_data             byte offered to the tx core
//     tx_ready/tx_done             tx core accept and byte-finished pulse
//     grant_id/busy                current owner and grant-held flag
//     timeout_err/trunc_err        1-cycle error pulses
//   Modports:
//     master  the arbiter's view (it masters the tx core)
//     slave   the environment: requesters plus tx core
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic               tx_done;
  logic [2:0]         grant_id;
  logic               busy;
  logic               timeout_err;
  logic               trunc_err;

  modport master (
    input  req_valid, req_data, req_last, tx_ready, tx_done,
    output req_ready, tx_valid, tx_data, grant_id, busy, timeout_err, trunc_err
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready, tx_done,
    input  req_ready, tx_valid, tx_data, grant_id, busy, timeout_err, trunc_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmit core among N_REQ byte-stream requesters at
//   packet granularity. Round-robin grant, held until the owner's last byte
//   has finished shifting out, revoked after TIMEOUT idle cycles mid-packet
//   (0 disables) or released after MAX_PKT_LEN bytes.
//   Ports:
//     clk    single clock
//     reset  synchronous, active-high
//     bus    uart_tx_arbiter_if.master: requester streams, tx core handshake
//            and status (grant_id, busy, timeout_err, trunc_err)
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT     = 255,
  parameter int MAX_PKT_LEN = 64
) (
  input logic               clk,
  input logic               reset,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [7:0] MAX_LEN_C = 8'(MAX_PKT_LEN);
  localparam logic [3:0] N_C       = 4'(N_REQ);
  localparam logic [2:0] LAST_IDX  = 3'(N_REQ - 1);

  state_t      state, state_next;
  logic [2:0]  rr_ptr, rr_ptr_next;
  logic [2:0]  grant_q, grant_next;
  logic        last_q, last_next;
  logic [7:0]  byte_cnt, byte_next;
  logic [7:0]  idle_cnt, idle_next;
  logic [2:0]  winner;
  logic        found;
  logic [3:0]  probe;

  // Requester lanes are padded to 8 so a 3-bit grant index always fits.
  logic [7:0]  valid_pad, last_pad;
  logic [63:0] data_pad;
  logic        cur_valid, cur_last;
  logic [7:0]  cur_data;

  assign valid_pad = 8'(bus.req_valid);
  assign last_pad  = 8'(bus.req_last);
  assign data_pad  = 64'(bus.req_data);
  assign cur_valid = valid_pad[grant_q];
  assign cur_last  = last_pad[grant_q];
  assign cur_data  = data_pad[{grant_q, 3'b000} +: 8];

  assign bus.grant_id = grant_q;
  assign bus.busy     = (state != IDLE);

  // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    probe  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      probe = {1'b0, rr_ptr} + 4'(k);
      if (probe >= N_C) probe = probe - N_C;
      if (!found && valid_pad[probe[2:0]]) begin
        found  = 1'b1;
        winner = probe[2:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      last_q   <= 1'b0;
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_ptr_next;
      grant_q  <= grant_next;
      last_q   <= last_next;
      byte_cnt <= byte_next;
      idle_cnt <= idle_next;
    end
  end

  always_comb begin
    state_next      = state;
    rr_ptr_next     = rr_ptr;
    grant_next      = grant_q;
    last_next       = last_q;
    byte_next       = byte_cnt;
    idle_next       = idle_cnt;
    bus.tx_valid    = 1'b0;
    bus.tx_data     = '0;
    bus.req_ready   = '0;
    bus.timeout_err = 1'b0;
    bus.trunc_err   = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          state_next  = SEND;
          grant_next  = winner;
          rr_ptr_next = (winner == LAST_IDX) ? 3'd0 : winner + 3'd1;
          byte_next   = '0;
          idle_next   = '0;
          last_next   = 1'b0;
        end
      end

      SEND: begin
        bus.tx_valid = cur_valid;
        bus.tx_data  = cur_data;
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_q == 3'(i)) bus.req_ready[i] = bus.tx_ready;
        end
        // An accepted byte wins over a timeout expiring in the same cycle,
        // so a byte the requester saw as accepted is never thrown away.
        if (cur_valid && bus.tx_ready) begin
          last_next  = cur_last;
          byte_next  = (byte_cnt == 8'hFF) ? byte_cnt : byte_cnt + 8'd1;
          idle_next  = '0;
          state_next = WAIT_DONE;
        end else begin
          if (!cur_valid && idle_cnt != 8'hFF) idle_next = idle_cnt + 8'd1;
          if ((TIMEOUT != 0) && (idle_cnt >= TIMEOUT_C)) begin
            bus.timeout_err = 1'b1;
            state_next      = IDLE;
          end
        end
      end

      WAIT_DONE: begin
        if (bus.tx_done) begin
          if (last_q) begin
            state_next = IDLE;
          end else if (byte_cnt >= MAX_LEN_C) begin
            bus.trunc_err = 1'b1;
            state_next    = IDLE;
          end else begin
            state_next = SEND;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
